// File: rtl/demux_dispatcher.sv
// Valid/ready 1-to-4 dispatcher: one-entry holding buffer that steers each word
// to a channel by round-robin over enabled channels or by a per-word destination.
module demux_dispatcher #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  output logic              in_ready,
  input  logic              mode,
  input  logic [3:0]        ch_en,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic [7:0]        drop_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [DATA_W-1:0] hold_buf;

  logic       transfer;
  logic       delivery;
  logic       has_tgt;
  logic [1:0] tgt;
  logic [1:0] idx;

  assign in_ready = (state == EMPTY) | out_ready[sel];
  assign transfer = in_valid & in_ready;
  assign delivery = (state == FULL) & out_ready[sel];

  // Round-robin search starts from the pointer as it stands before this edge's delivery update.
  always_comb begin
    has_tgt = 1'b0;
    tgt     = rr_ptr;
    idx     = rr_ptr;
    if (mode) begin
      tgt     = in_dest;
      has_tgt = ch_en[in_dest];
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        idx = rr_ptr + 2'(k);
        if (!has_tgt && ch_en[idx]) begin
          has_tgt = 1'b1;
          tgt     = idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      sel      <= '0;
      hold_buf <= '0;
      drop_cnt <= '0;
    end else begin
      if (delivery) rr_ptr <= sel + 2'd1;
      if (transfer && has_tgt) begin
        hold_buf <= in_data;
        sel      <= tgt;
        state    <= FULL;
      end else begin
        // A drop while FULL implies a same-edge delivery (in_ready needs out_ready[sel]),
        // so emptying on delivery alone covers both the drop and no-transfer cases.
        if (transfer && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        if (delivery) state <= EMPTY;
      end
    end
  end

  always_comb begin
    out_valid = '0;
    if (state == FULL) out_valid[sel] = 1'b1;
  end

  assign out_data = hold_buf;

endmodule

// File: tb/tb_demux_dispatcher.sv
// Self-checking bench for demux_dispatcher: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_demux_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       in_ready;
  logic       mode;
  logic [3:0] ch_en;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [3:0] out_ready;
  logic [1:0] sel;
  logic [7:0] drop_cnt;

  int total;
  int bad;

  demux_dispatcher #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .mode      (mode),
    .ch_en     (ch_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [1:0] dest;
    logic       md;
    logic [3:0] en;
    logic [3:0] ordy;
    logic [3:0] ov;
    logic [7:0] od;
    logic [7:0] dc;
  } vec_t;

  vec_t tbl[38];

  function automatic vec_t mk(logic v, logic [7:0] d, logic [1:0] dest, logic md,
                              logic [3:0] en, logic [3:0] ordy,
                              logic [3:0] ov, logic [7:0] od, logic [7:0] dc);
    vec_t r;
    r.v = v; r.d = d; r.dest = dest; r.md = md; r.en = en; r.ordy = ordy;
    r.ov = ov; r.od = od; r.dc = dc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] dest,
                       input logic md, input logic [3:0] en, input logic [3:0] ordy);
    in_valid = v; in_data = d; in_dest = dest; mode = md; ch_en = en; out_ready = ordy;
  endtask

  // Reference model state: holding flag, channel, word, rotation pointer, drop count.
  logic       m_full;
  logic [1:0] m_sel;
  logic [7:0] m_buf;
  int         m_ptr;
  int         m_dc;

  task automatic model_edge();
    bit deliver, rdy, xfer, found;
    int t;
    deliver = m_full && out_ready[m_sel];
    rdy     = !m_full || out_ready[m_sel];
    xfer    = in_valid && rdy;
    found   = 0;
    t       = 0;
    if (mode) begin
      t = in_dest;
      found = ch_en[in_dest];
    end else begin
      for (int k = 0; k < 4; k++)
        if (!found && ch_en[(m_ptr + k) % 4]) begin
          found = 1;
          t = (m_ptr + k) % 4;
        end
    end
    if (deliver) begin
      m_ptr = (m_sel + 1) % 4;
      m_full = 0;
    end
    if (xfer) begin
      if (found) begin
        m_buf = in_data;
        m_sel = 2'(t);
        m_full = 1;
      end else if (m_dc < 255) begin
        m_dc++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(0, 8'h00, 2'd0, 0, 4'b1111, 4'b1111);

    // Round-robin, spaced so each word is delivered before the next arrives.
    tbl[0]  = mk(1, 8'h11, 0, 0, 4'b1111, 4'b1111, 4'b0001, 8'h11, 0);
    tbl[1]  = mk(0, 8'h00, 0, 0, 4'b1111, 4'b1111, 4'b0000, 8'h11, 0);
    tbl[2]  = mk(1, 8'h22, 0, 0, 4'b1111, 4'b1111, 4'b0010, 8'h22, 0);
    tbl[3]  = mk(0, 8'h00, 0, 0, 4'b1111, 4'b1111, 4'b0000, 8'h22, 0);
    tbl[4]  = mk(1, 8'h33, 0, 0, 4'b1111, 4'b1111, 4'b0100, 8'h33, 0);
    tbl[5]  = mk(0, 8'h00, 0, 0, 4'b1111, 4'b1111, 4'b0000, 8'h33, 0);
    tbl[6]  = mk(1, 8'h44, 0, 0, 4'b1111, 4'b1111, 4'b1000, 8'h44, 0);
    tbl[7]  = mk(0, 8'h00, 0, 0, 4'b1111, 4'b1111, 4'b0000, 8'h44, 0);
    tbl[8]  = mk(1, 8'h55, 0, 0, 4'b1111, 4'b1111, 4'b0001, 8'h55, 0);
    tbl[9]  = mk(0, 8'h00, 0, 0, 4'b1111, 4'b1111, 4'b0000, 8'h55, 0);
    // Back-to-back: second word searches from the pre-update pointer and re-selects ch1.
    tbl[10] = mk(1, 8'h66, 0, 0, 4'b1111, 4'b1111, 4'b0010, 8'h66, 0);
    tbl[11] = mk(1, 8'h77, 0, 0, 4'b1111, 4'b1111, 4'b0010, 8'h77, 0);
    tbl[12] = mk(0, 8'h00, 0, 0, 4'b1111, 4'b1111, 4'b0000, 8'h77, 0);
    // Masked rotation over channels 1 and 3, pointer at 2.
    tbl[13] = mk(1, 8'h81, 0, 0, 4'b1010, 4'b1111, 4'b1000, 8'h81, 0);
    tbl[14] = mk(0, 8'h00, 0, 0, 4'b1010, 4'b1111, 4'b0000, 8'h81, 0);
    tbl[15] = mk(1, 8'h82, 0, 0, 4'b1010, 4'b1111, 4'b0010, 8'h82, 0);
    tbl[16] = mk(0, 8'h00, 0, 0, 4'b1010, 4'b1111, 4'b0000, 8'h82, 0);
    tbl[17] = mk(1, 8'h83, 0, 0, 4'b1010, 4'b1111, 4'b1000, 8'h83, 0);
    tbl[18] = mk(0, 8'h00, 0, 0, 4'b1010, 4'b1111, 4'b0000, 8'h83, 0);
    tbl[19] = mk(1, 8'h84, 0, 0, 4'b1010, 4'b1111, 4'b0010, 8'h84, 0);
    tbl[20] = mk(0, 8'h00, 0, 0, 4'b1010, 4'b1111, 4'b0000, 8'h84, 0);
    tbl[21] = mk(1, 8'h85, 0, 0, 4'b1010, 4'b1111, 4'b1000, 8'h85, 0);
    tbl[22] = mk(0, 8'h00, 0, 0, 4'b1010, 4'b1111, 4'b0000, 8'h85, 0);
    // No channel enabled: three drops.
    tbl[23] = mk(1, 8'h90, 0, 0, 4'b0000, 4'b1111, 4'b0000, 8'h85, 1);
    tbl[24] = mk(1, 8'h91, 0, 0, 4'b0000, 4'b1111, 4'b0000, 8'h85, 2);
    tbl[25] = mk(1, 8'h92, 0, 0, 4'b0000, 4'b1111, 4'b0000, 8'h85, 3);
    // Directed with backpressure, then simultaneous delivery and transfer.
    tbl[26] = mk(1, 8'hA5, 2, 1, 4'b1111, 4'b0000, 4'b0100, 8'hA5, 3);
    tbl[27] = mk(1, 8'h5A, 0, 1, 4'b1111, 4'b0000, 4'b0100, 8'hA5, 3);
    tbl[28] = mk(1, 8'h5A, 0, 1, 4'b1111, 4'b0000, 4'b0100, 8'hA5, 3);
    tbl[29] = mk(1, 8'h5A, 0, 1, 4'b1111, 4'b0000, 4'b0100, 8'hA5, 3);
    tbl[30] = mk(1, 8'h5A, 0, 1, 4'b1111, 4'b0000, 4'b0100, 8'hA5, 3);
    tbl[31] = mk(1, 8'h5A, 0, 1, 4'b1111, 4'b0100, 4'b0001, 8'h5A, 3);
    tbl[32] = mk(0, 8'h00, 0, 1, 4'b1111, 4'b1111, 4'b0000, 8'h5A, 3);
    // Mask change while FULL: held word still goes to channel 3.
    tbl[33] = mk(1, 8'hC3, 3, 1, 4'b1111, 4'b0000, 4'b1000, 8'hC3, 3);
    tbl[34] = mk(0, 8'h00, 0, 1, 4'b0111, 4'b0000, 4'b1000, 8'hC3, 3);
    tbl[35] = mk(0, 8'h00, 0, 1, 4'b0111, 4'b1000, 4'b0000, 8'hC3, 3);
    tbl[36] = mk(1, 8'hD4, 0, 0, 4'b0110, 4'b0000, 4'b0010, 8'hD4, 3);
    tbl[37] = mk(0, 8'h00, 0, 0, 4'b0110, 4'b0010, 4'b0000, 8'hD4, 3);

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 38; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].dest, tbl[i].md, tbl[i].en, tbl[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].dc));
    end

    // Directed drops saturate the counter; nothing is ever presented downstream.
    for (int i = 0; i < 300; i++) begin
      drive(1, 8'(i), 2'd0, 1, 4'b1110, 4'b1111);
      @(posedge clk); #1;
      chk("sat_out_valid", 32'(out_valid), 32'h0);
      chk("sat_in_ready", 32'(in_ready), 32'h1);
    end
    chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);

    // Asynchronous reset while holding a word on channel 2.
    drive(1, 8'hA5, 2'd2, 1, 4'b1111, 4'b0000);
    @(posedge clk); #1;
    drive(0, 8'h00, 2'd0, 1, 4'b1111, 4'b0000);
    #2;
    chk("pre_arst_out_valid", 32'(out_valid), 32'h4);
    chk("pre_arst_in_ready", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("arst_sel", 32'(sel), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    chk("arst_out_data", 32'(out_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("deassert_in_ready", 32'(in_ready), 32'h1);

    // Randomized traffic against the behavioural model.
    m_full = 0; m_sel = 0; m_buf = 0; m_ptr = 0; m_dc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
            1'($urandom), ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom),
            4'($urandom));
      #2;
      chk("rnd_in_ready", 32'(in_ready), 32'(!m_full || out_ready[m_sel]));
      chk("rnd_out_valid", 32'(out_valid), m_full ? (32'h1 << m_sel) : 32'h0);
      chk("rnd_out_data", 32'(out_data), 32'(m_buf));
      chk("rnd_sel", 32'(sel), 32'(m_sel));
      chk("rnd_drop_cnt", 32'(drop_cnt), 32'(m_dc));
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
